// File: rtl/btn_click_decoder_pkg.sv
// Shared constants for the button click decoder: state encoding, click-count
// width and the click classification codes.
package btn_pkg;

    // One-hot FSM encoding; any other value is illegal and recovers to idle.
    localparam logic [2:0] ST_IDLE  = 3'b001;
    localparam logic [2:0] ST_COUNT = 3'b010;
    localparam logic [2:0] ST_EMIT  = 3'b100;

    localparam int unsigned CLICK_W = 2;

    localparam logic [CLICK_W-1:0] CLK_SINGLE = 2'd1;
    localparam logic [CLICK_W-1:0] CLK_DOUBLE = 2'd2;
    localparam logic [CLICK_W-1:0] CLK_TRIPLE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_COUNT = ST_COUNT,
        S_EMIT  = ST_EMIT
    } state_e;

endpackage

// File: rtl/btn_click_decoder_if.sv
// Press-strobe input and classified click-event outputs of the decoder.
// master = upstream / front-panel side, slave = the decoder itself.
interface btn_click_decoder_if;

    logic                          PULSE;
    logic                          CLICK_VLD;
    logic [btn_pkg::CLICK_W-1:0]   CLICK_NUM;
    logic                          SINGLE;
    logic                          DOUBLE;
    logic                          TRIPLE;
    logic                          BUSY;

    modport master (
        output PULSE,
        input  CLICK_VLD, CLICK_NUM, SINGLE, DOUBLE, TRIPLE, BUSY
    );

    modport slave (
        input  PULSE,
        output CLICK_VLD, CLICK_NUM, SINGLE, DOUBLE, TRIPLE, BUSY
    );

endinterface

// File: rtl/btn_click_decoder_timer.sv
// Window timer: counts idle cycles since the last press. expired is decoded
// from the registered count so the FSM sees it in the cycle the count hits
// WIN_CNT-1, and only while counting is enabled (no press this cycle).
module click_win_timer #(
    parameter int unsigned WIN_CNT = 12_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [31:0] LAST = 32'(WIN_CNT - 1);

    logic [31:0] cnt_q;

    // Clear on a press, otherwise count up while enabled; saturate instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RST || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/btn_click_decoder.sv
// Click decoder: groups debounced press strobes into a window and reports one
// single/double/triple event when the window times out or fills up.
module btn_click_decoder
    import btn_pkg::*;
#(
    parameter int unsigned WIN_CNT    = 1_000_000 * 12,
    parameter int unsigned MAX_CLICKS = 3
) (
    input  logic                CLK,
    input  logic                RST,
    btn_click_decoder_if.slave  bus
);

    if (MAX_CLICKS < 1 || MAX_CLICKS > 3) begin : g_bad_max
        $error("btn_click_decoder: MAX_CLICKS must be in 1..3");
    end

    localparam logic [CLICK_W-1:0] MAX_C = CLICK_W'(MAX_CLICKS);

    state_e               state_q;
    logic [CLICK_W-1:0]   count_q;
    logic                 vld_q;
    logic [CLICK_W-1:0]   num_q;
    logic                 single_q;
    logic                 double_q;
    logic                 triple_q;
    logic                 busy_q;
    logic                 expired;
    logic                 tmr_en;

    // Timer only advances on press-free cycles of an open window, so a press
    // landing on the timeout cycle wins and restarts the window.
    assign tmr_en = (state_q == S_COUNT) && !bus.PULSE;

    click_win_timer #(.WIN_CNT(WIN_CNT)) u_timer (
        .CLK       (CLK),
        .RST       (RST),
        .clr_i     (bus.PULSE),
        .en_i      (tmr_en),
        .expired_o (expired)
    );

    // FSM, click counter and registered event outputs. Event outputs are
    // loaded on the edge entering EMIT so they are high for exactly the EMIT
    // cycle; a full window is closed one cycle after the count reaches MAX.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            vld_q    <= 1'b0;
            num_q    <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            triple_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            vld_q    <= 1'b0;
            num_q    <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            triple_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (bus.PULSE) begin
                        count_q <= CLK_SINGLE;
                        busy_q  <= 1'b1;
                        if (MAX_C == CLK_SINGLE) begin
                            state_q  <= S_EMIT;
                            vld_q    <= 1'b1;
                            num_q    <= CLK_SINGLE;
                            single_q <= 1'b1;
                        end else begin
                            state_q <= S_COUNT;
                        end
                    end
                end
                S_COUNT: begin
                    busy_q <= 1'b1;
                    if ((count_q == MAX_C) || (!bus.PULSE && expired)) begin
                        state_q  <= S_EMIT;
                        vld_q    <= 1'b1;
                        num_q    <= count_q;
                        single_q <= (count_q == CLK_SINGLE);
                        double_q <= (count_q == CLK_DOUBLE);
                        triple_q <= (count_q == CLK_TRIPLE);
                    end else if (bus.PULSE) begin
                        count_q <= count_q + 1'b1;
                    end
                end
                S_EMIT: begin
                    // A press during the report opens the next window immediately.
                    if (bus.PULSE) begin
                        count_q <= CLK_SINGLE;
                        state_q <= S_COUNT;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    count_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CLICK_VLD = vld_q;
    assign bus.CLICK_NUM = num_q;
    assign bus.SINGLE    = single_q;
    assign bus.DOUBLE    = double_q;
    assign bus.TRIPLE    = triple_q;
    assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_btn_click_decoder.sv
// Scoreboard bench for btn_click_decoder (WIN_CNT=10, MAX_CLICKS=3).
// Stimulus pushes expected events (cycle, count); a negedge monitor pops and
// compares whenever CLICK_VLD is seen, and flags any stray event output.
module tb_btn_click_decoder;

    localparam int unsigned WIN = 10;

    typedef struct {
        int         at;
        logic [1:0] num;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    btn_click_decoder_if bus ();

    btn_click_decoder #(.WIN_CNT(WIN), .MAX_CLICKS(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    function automatic logic [2:0] hot(input logic [1:0] n);
        return {n == 2'd1, n == 2'd2, n == 2'd3};
    endfunction

    // Monitor: every reported event must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (bus.CLICK_VLD) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event: cyc=%0d num=%0d, no event required", cyc, bus.CLICK_NUM);
                end else begin
                    mon_e = sb.pop_front();
                    if (cyc != mon_e.at || bus.CLICK_NUM != mon_e.num ||
                        {bus.SINGLE, bus.DOUBLE, bus.TRIPLE} != hot(mon_e.num)) begin
                        miscompares++;
                        $display("FAIL event: got cyc=%0d num=%0d sdt=%b, required cyc=%0d num=%0d sdt=%b",
                                 cyc, bus.CLICK_NUM, {bus.SINGLE, bus.DOUBLE, bus.TRIPLE},
                                 mon_e.at, mon_e.num, hot(mon_e.num));
                    end
                end
            end else if (bus.CLICK_NUM != 2'd0 || bus.SINGLE || bus.DOUBLE || bus.TRIPLE) begin
                vectors++;
                miscompares++;
                $display("FAIL idle_outputs: cyc=%0d num=%0d sdt=%b, required 0/000", cyc,
                         bus.CLICK_NUM, {bus.SINGLE, bus.DOUBLE, bus.TRIPLE});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulse();
        bus.PULSE = 1'b1;
        tick(1);
        bus.PULSE = 1'b0;
    endtask

    task automatic expect_evt(input int at, input logic [1:0] n);
        exp_t e;
        e.at  = at;
        e.num = n;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: cyc=%0d got %0d, required %0d", nm, cyc, got, exp);
        end
    endtask

    initial begin
        int t0;
        bus.PULSE = 1'b0;
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        mon_en = 1'b1;

        // 1: quiet after reset
        chk("rst_vld", int'(bus.CLICK_VLD), 0);
        chk("rst_num", int'(bus.CLICK_NUM), 0);
        chk("rst_busy", int'(bus.BUSY), 0);
        for (int i = 0; i < 50; i++) begin
            tick(1);
            chk("quiet_busy", int'(bus.BUSY), 0);
            chk("quiet_vld", int'(bus.CLICK_VLD), 0);
        end

        // 2: single press, timeout path
        t0 = cyc;
        pulse();
        expect_evt(t0 + 11, 2'd1);
        tick(4);
        chk("single_busy_mid", int'(bus.BUSY), 1);
        tick(6);
        chk("single_busy_emit", int'(bus.BUSY), 1);
        tick(1);
        chk("single_busy_after", int'(bus.BUSY), 0);
        tick(5);

        // 3: double press, timer restarts on the second press
        t0 = cyc;
        pulse();
        tick(5);
        pulse();
        expect_evt(t0 + 17, 2'd2);
        tick(20);

        // 4: triple press closes the window at MAX
        t0 = cyc;
        pulse();
        tick(3);
        pulse();
        tick(3);
        pulse();
        expect_evt(t0 + 10, 2'd3);
        tick(2);
        chk("triple_busy_after", int'(bus.BUSY), 0);
        tick(18);

        // 5: press on the timeout cycle is counted, window extends
        t0 = cyc;
        pulse();
        tick(9);
        pulse();
        expect_evt(t0 + 21, 2'd2);
        chk("edge_no_event", int'(bus.CLICK_VLD), 0);
        tick(20);

        // 6: reset abandons the window; press on EMIT starts a new window
        t0 = cyc;
        pulse();
        tick(4);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        chk("abort_busy", int'(bus.BUSY), 0);
        chk("abort_vld", int'(bus.CLICK_VLD), 0);
        tick(20);
        chk("abort_busy_late", int'(bus.BUSY), 0);
        t0 = cyc;
        pulse();
        expect_evt(t0 + 11, 2'd1);
        tick(10);
        chk("emit_vld", int'(bus.CLICK_VLD), 1);
        pulse();
        expect_evt(t0 + 22, 2'd1);
        chk("emit_reopen_busy", int'(bus.BUSY), 1);
        tick(25);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
